// File: rtl/universal_binary_counter_if.sv
// Command/status bundle for the universal binary counter.
// master drives commands and observes the count; slave is the counter itself.
interface universal_binary_counter_if #(
  parameter int N = 8
);
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic [N-1:0] d;
  logic         max;
  logic         min;
  logic [N-1:0] q;

  modport master (
    output syn_clr, load, en, up, d,
    input  max, min, q
  );

  modport slave (
    input  syn_clr, load, en, up, d,
    output max, min, q
  );
endinterface

// File: rtl/universal_binary_counter.sv
// N-bit up/down counter with synchronous clear, parallel load and count enable.
// Terminal-count flags are decoded combinationally from the count register.
module universal_binary_counter #(
  parameter int N = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  universal_binary_counter_if.slave    bus
);

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_CLR,
    CMD_LOAD,
    CMD_INC,
    CMD_DEC
  } cmd_e;

  cmd_e         cmd;
  logic [N-1:0] q_d;
  logic [N-1:0] q_q;

  // Strict priority: clear beats load beats counting; up only matters when counting.
  always_comb begin
    cmd = CMD_HOLD;
    if (bus.syn_clr)     cmd = CMD_CLR;
    else if (bus.load)   cmd = CMD_LOAD;
    else if (bus.en)     cmd = bus.up ? CMD_INC : CMD_DEC;
  end

  // Natural modulo-2^N wrap in both directions, no saturation.
  always_comb begin
    q_d = q_q;
    unique case (cmd)
      CMD_CLR:  q_d = '0;
      CMD_LOAD: q_d = bus.d;
      CMD_INC:  q_d = q_q + N'(1);
      CMD_DEC:  q_d = q_q - N'(1);
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign bus.q   = q_q;
  assign bus.max = &q_q;
  assign bus.min = ~|q_q;

endmodule

// File: tb/tb_universal_binary_counter.sv
// Scoreboarded bench: the driver pushes the model's expected count after each
// edge, and a negedge monitor pops and compares count and flags.
module tb_universal_binary_counter;
  localparam int N    = 8;
  localparam int MODV = 1 << N;
  localparam int MAXV = MODV - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   model_q;
  int   exp_q[$];

  universal_binary_counter_if #(.N(N)) intf ();

  universal_binary_counter #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      int e;
      e = exp_q.pop_front();
      check("q",   int'(intf.q),   e);
      check("min", int'(intf.min), (e == 0)    ? 1 : 0);
      check("max", int'(intf.max), (e == MAXV) ? 1 : 0);
    end
  end

  // Apply one command for one edge; the model is the plain-arithmetic rule set.
  task automatic step(input bit clr, input bit ld, input bit e, input bit u, input int dv);
    @(negedge clk);
    #1;
    intf.syn_clr = clr;
    intf.load    = ld;
    intf.en      = e;
    intf.up      = u;
    intf.d       = N'(dv);
    @(posedge clk);
    if (clr)         model_q = 0;
    else if (ld)     model_q = dv % MODV;
    else if (e && u) model_q = (model_q + 1) % MODV;
    else if (e)      model_q = (model_q + MODV - 1) % MODV;
    exp_q.push_back(model_q);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    intf.syn_clr = 1'b0;
    intf.load    = 1'b0;
    intf.en      = 1'b0;
    intf.up      = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_q",   int'(intf.q),   0);
    check("async_rst_min", int'(intf.min), 1);
    check("async_rst_max", int'(intf.max), 0);
    model_q = 0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    exp_q.push_back(model_q);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    model_q      = 0;
    reset        = 1'b1;
    intf.syn_clr = 1'b0;
    intf.load    = 1'b0;
    intf.en      = 1'b0;
    intf.up      = 1'b0;
    intf.d       = '0;
    #12;
    check("reset_q",   int'(intf.q),   0);
    check("reset_min", int'(intf.min), 1);
    check("reset_max", int'(intf.max), 0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset from a non-zero count.
    step(0, 1, 0, 0, 8'h37);
    pulse_reset();

    // Priority: clear wins over everything, load is not also incremented.
    step(1, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);

    for (int i = 0; i < 40; i++) step(0, 0, 1, 1, $urandom_range(0, MAXV));
    for (int i = 0; i < 41; i++) step(0, 0, 1, 0, $urandom_range(0, MAXV));
    step(0, 0, 1, 0, 0);

    // Wrap up through the top, then hold.
    step(0, 1, 0, 0, 254);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, MAXV));

    // Randomized mix, biased toward the wrap points.
    for (int i = 0; i < 400; i++) begin
      int sel;
      int dv;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       dv = 0;
        1:       dv = MAXV;
        2:       dv = MAXV - 1;
        3:       dv = 1;
        default: dv = $urandom_range(0, MAXV);
      endcase
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, dv);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
